// File: rtl/lcd_timing_gen.sv
// Parametrised LCD timing generator: H/V sync FSMs, early pixel request,
// latency-matched sync/DEN/RGB output, border test mode, interrupts and scroll offsets.
//
// state     | meaning
// ----------+---------------------------------------------
// ST_SYNC   | sync pulse asserted (H_PULSE clocks / V_PULSE lines)
// ST_BP     | back porch
// ST_ACTIVE | visible region, pixels requested
// ST_FP     | front porch, last state before wrap to ST_SYNC
module lcd_timing_gen #(
  parameter int unsigned H_ACTIVE = 800,
  parameter int unsigned H_FP     = 210,
  parameter int unsigned H_PULSE  = 1,
  parameter int unsigned H_BP     = 46,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 23,
  parameter int unsigned V_PULSE  = 5,
  parameter int unsigned V_BP     = 23,
  parameter bit          SYNC_POL = 1'b0,
  parameter int unsigned PIPE_LAT = 2
) (
  input  logic        clk_pix,
  input  logic        reset,
  output logic        pix_valid,
  output logic [15:0] pix_x,
  output logic [15:0] pix_y,
  input  logic [15:0] pix_rgb,
  input  logic [15:0] offset_x_in,
  input  logic [15:0] offset_y_in,
  output logic [15:0] offset_x,
  output logic [15:0] offset_y,
  input  logic [15:0] line_int_at,
  input  logic        border_en,
  output logic        LCD_HSYNC,
  output logic        LCD_VSYNC,
  output logic        LCD_DEN,
  output logic [4:0]  LCD_R,
  output logic [5:0]  LCD_G,
  output logic [4:0]  LCD_B,
  output logic        frame_int,
  output logic        line_int
);

  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  localparam int unsigned H_MAX = max4(H_ACTIVE, H_FP, H_PULSE, H_BP);
  localparam int unsigned V_MAX = max4(V_ACTIVE, V_FP, V_PULSE, V_BP);
  localparam int unsigned H_CW  = (H_MAX > 1) ? $clog2(H_MAX) : 1;
  localparam int unsigned V_CW  = (V_MAX > 1) ? $clog2(V_MAX) : 1;

  localparam logic [H_CW-1:0] H_SYNC_LAST = H_CW'(H_PULSE - 1);
  localparam logic [H_CW-1:0] H_BP_LAST   = H_CW'(H_BP - 1);
  localparam logic [H_CW-1:0] H_ACT_LAST  = H_CW'(H_ACTIVE - 1);
  localparam logic [H_CW-1:0] H_FP_LAST   = H_CW'(H_FP - 1);
  localparam logic [V_CW-1:0] V_SYNC_LAST = V_CW'(V_PULSE - 1);
  localparam logic [V_CW-1:0] V_BP_LAST   = V_CW'(V_BP - 1);
  localparam logic [V_CW-1:0] V_ACT_LAST  = V_CW'(V_ACTIVE - 1);
  localparam logic [V_CW-1:0] V_FP_LAST   = V_CW'(V_FP - 1);

  typedef enum logic [1:0] {
    ST_SYNC   = 2'd0,
    ST_BP     = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_FP     = 2'd3
  } tstate_e;

  tstate_e         h_st_q, h_st_d, v_st_q, v_st_d;
  logic [H_CW-1:0] h_cnt_q, h_cnt_d;
  logic [V_CW-1:0] v_cnt_q, v_cnt_d;
  logic            h_last, v_last, h_wrap, frame_wrap;
  logic            hs_q, hs_d, vs_q, vs_d, den_q, den_d;
  logic [15:0]     rgb_q, rgb_d;
  logic            frame_int_q, frame_int_d, line_int_q, line_int_d;
  logic [15:0]     offset_x_q, offset_x_d, offset_y_q, offset_y_d;
  logic            border0;
  logic [3:0]      stg0, stg_last;

  always_comb begin
    h_last = 1'b0;
    unique case (h_st_q)
      ST_SYNC:   h_last = (h_cnt_q == H_SYNC_LAST);
      ST_BP:     h_last = (h_cnt_q == H_BP_LAST);
      ST_ACTIVE: h_last = (h_cnt_q == H_ACT_LAST);
      ST_FP:     h_last = (h_cnt_q == H_FP_LAST);
      default:   h_last = 1'b1;
    endcase
    v_last = 1'b0;
    unique case (v_st_q)
      ST_SYNC:   v_last = (v_cnt_q == V_SYNC_LAST);
      ST_BP:     v_last = (v_cnt_q == V_BP_LAST);
      ST_ACTIVE: v_last = (v_cnt_q == V_ACT_LAST);
      ST_FP:     v_last = (v_cnt_q == V_FP_LAST);
      default:   v_last = 1'b1;
    endcase

    h_wrap     = h_last && (h_st_q == ST_FP);
    frame_wrap = h_wrap && v_last && (v_st_q == ST_FP);

    h_st_d  = h_st_q;
    h_cnt_d = h_cnt_q + H_CW'(1);
    if (h_last) begin
      h_cnt_d = '0;
      h_st_d  = tstate_e'(h_st_q + 2'd1);
    end

    // The vertical FSM only moves on the last clock of a line.
    v_st_d  = v_st_q;
    v_cnt_d = v_cnt_q;
    if (h_wrap) begin
      v_cnt_d = v_cnt_q + V_CW'(1);
      if (v_last) begin
        v_cnt_d = '0;
        v_st_d  = tstate_e'(v_st_q + 2'd1);
      end
    end
  end

  assign pix_valid = (h_st_q == ST_ACTIVE) && (v_st_q == ST_ACTIVE);
  assign pix_x     = pix_valid ? 16'(h_cnt_q) : 16'd0;
  assign pix_y     = pix_valid ? 16'(v_cnt_q) : 16'd0;

  assign border0 = border_en && pix_valid &&
                   ((h_cnt_q == '0) || (h_cnt_q == H_ACT_LAST) ||
                    (v_cnt_q == '0) || (v_cnt_q == V_ACT_LAST));

  assign stg0 = {h_st_q == ST_SYNC, v_st_q == ST_SYNC, pix_valid, border0};

  generate
    if (PIPE_LAT == 0) begin : g_nodly
      assign stg_last = stg0;
    end else begin : g_dly
      logic [4*PIPE_LAT-1:0] dly_q, dly_d;
      if (PIPE_LAT == 1) begin : g_one
        assign dly_d = stg0;
      end else begin : g_many
        assign dly_d = {dly_q[4*PIPE_LAT-5:0], stg0};
      end
      always_ff @(posedge clk_pix or negedge reset) begin
        if (!reset) dly_q <= '0;
        else        dly_q <= dly_d;
      end
      assign stg_last = dly_q[4*PIPE_LAT-1 -: 4];
    end
  endgenerate

  always_comb begin
    hs_d  = stg_last[3] ^ ~SYNC_POL;
    vs_d  = stg_last[2] ^ ~SYNC_POL;
    den_d = stg_last[1];
    if (!stg_last[1])     rgb_d = 16'h0000;
    else if (stg_last[0]) rgb_d = 16'hFFFF;
    else                  rgb_d = pix_rgb;

    frame_int_d = frame_wrap;
    // Predicted from next-state so the pulse lands on the first visible clock.
    line_int_d  = (h_st_d == ST_ACTIVE) && (h_cnt_d == '0) &&
                  (v_st_d == ST_ACTIVE) && (16'(v_cnt_d) == line_int_at);

    offset_x_d = frame_wrap ? offset_x_in : offset_x_q;
    offset_y_d = frame_wrap ? offset_y_in : offset_y_q;
  end

  always_ff @(posedge clk_pix or negedge reset) begin
    if (!reset) begin
      h_st_q      <= ST_SYNC;
      v_st_q      <= ST_SYNC;
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      hs_q        <= ~SYNC_POL;
      vs_q        <= ~SYNC_POL;
      den_q       <= 1'b0;
      rgb_q       <= 16'h0000;
      frame_int_q <= 1'b0;
      line_int_q  <= 1'b0;
      offset_x_q  <= 16'h0000;
      offset_y_q  <= 16'h0000;
    end else begin
      h_st_q      <= h_st_d;
      v_st_q      <= v_st_d;
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      den_q       <= den_d;
      rgb_q       <= rgb_d;
      frame_int_q <= frame_int_d;
      line_int_q  <= line_int_d;
      offset_x_q  <= offset_x_d;
      offset_y_q  <= offset_y_d;
    end
  end

  assign LCD_HSYNC = hs_q;
  assign LCD_VSYNC = vs_q;
  assign LCD_DEN   = den_q;
  assign LCD_R     = rgb_q[15:11];
  assign LCD_G     = rgb_q[10:5];
  assign LCD_B     = rgb_q[4:0];
  assign frame_int = frame_int_q;
  assign line_int  = line_int_q;
  assign offset_x  = offset_x_q;
  assign offset_y  = offset_y_q;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Directed bench for lcd_timing_gen on a 15x8 raster: timing, pixel alignment,
// border mode, offsets, interrupts, and async reset on a SYNC_POL=1 / PIPE_LAT=0 copy.
module tb_lcd_timing_gen;

  localparam int HT = 15;
  localparam int VT = 8;
  localparam int FT = HT * VT;

  logic        clk_pix = 1'b0;
  logic        rst_n, rst2_n;
  logic [15:0] pix_rgb, pix_rgb2;
  logic [15:0] offset_x_in, offset_y_in, line_int_at;
  logic        border_en, fixed_mode;
  logic [15:0] p0, p1;

  logic        pix_valid, LCD_HSYNC, LCD_VSYNC, LCD_DEN, frame_int, line_int;
  logic [15:0] pix_x, pix_y, offset_x, offset_y;
  logic [4:0]  LCD_R, LCD_B;
  logic [5:0]  LCD_G;

  logic        pix_valid2, LCD_HSYNC2, LCD_VSYNC2, LCD_DEN2, frame_int2, line_int2;
  logic [15:0] pix_x2, pix_y2, offset_x2, offset_y2;
  logic [4:0]  LCD_R2, LCD_B2;
  logic [5:0]  LCD_G2;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk_pix = ~clk_pix;

  lcd_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_PULSE(2), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_PULSE(1), .V_BP(2),
    .SYNC_POL(1'b0), .PIPE_LAT(2)
  ) dut (
    .clk_pix(clk_pix), .reset(rst_n),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
    .offset_x_in(offset_x_in), .offset_y_in(offset_y_in),
    .offset_x(offset_x), .offset_y(offset_y),
    .line_int_at(line_int_at), .border_en(border_en),
    .LCD_HSYNC(LCD_HSYNC), .LCD_VSYNC(LCD_VSYNC), .LCD_DEN(LCD_DEN),
    .LCD_R(LCD_R), .LCD_G(LCD_G), .LCD_B(LCD_B),
    .frame_int(frame_int), .line_int(line_int)
  );

  lcd_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_PULSE(2), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_PULSE(1), .V_BP(2),
    .SYNC_POL(1'b1), .PIPE_LAT(0)
  ) dut2 (
    .clk_pix(clk_pix), .reset(rst2_n),
    .pix_valid(pix_valid2), .pix_x(pix_x2), .pix_y(pix_y2), .pix_rgb(pix_rgb2),
    .offset_x_in(offset_x_in), .offset_y_in(offset_y_in),
    .offset_x(offset_x2), .offset_y(offset_y2),
    .line_int_at(line_int_at), .border_en(border_en),
    .LCD_HSYNC(LCD_HSYNC2), .LCD_VSYNC(LCD_VSYNC2), .LCD_DEN(LCD_DEN2),
    .LCD_R(LCD_R2), .LCD_G(LCD_G2), .LCD_B(LCD_B2),
    .frame_int(frame_int2), .line_int(line_int2)
  );

  // Two-stage external pixel pipeline returning {y, x, 0}.
  always @(posedge clk_pix) begin
    p0 <= {pix_y[4:0], pix_x[5:0], 5'd0};
    p1 <= p0;
  end
  assign pix_rgb = fixed_mode ? 16'h1234 : p1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit act_at(input int s);
    int hp, ln;
    if (s < 0) return 1'b0;
    hp = s % HT;
    ln = (s / HT) % VT;
    return (hp >= 5) && (hp < 13) && (ln >= 3) && (ln < 7);
  endfunction

  function automatic int hx(input int s);
    return (s % HT) - 5;
  endfunction

  function automatic int vy(input int s);
    return ((s / HT) % VT) - 3;
  endfunction

  initial begin
    int f, s, x, y, lia, first_den;
    int hs_low, vs_low, den_cnt, pv_cnt, fi_cnt, li_cnt;
    bit a, as_, bord, hs_a, vs_a;
    logic [15:0] rexp;

    rst_n = 1'b1; rst2_n = 1'b1;
    offset_x_in = 16'd5; offset_y_in = 16'hFFFD; line_int_at = 16'd2;
    border_en = 1'b0; fixed_mode = 1'b0; pix_rgb2 = 16'hA5A5;
    p0 = '0; p1 = '0;
    #2;
    rst_n = 1'b0; rst2_n = 1'b0;
    @(negedge clk_pix);
    @(negedge clk_pix);

    chk("rst_hsync", LCD_HSYNC, 1'b1);
    chk("rst_vsync", LCD_VSYNC, 1'b1);
    chk("rst_den", LCD_DEN, 1'b0);
    chk("rst_rgb", {LCD_R, LCD_G, LCD_B}, 16'h0);
    chk("rst_pix_valid", pix_valid, 1'b0);
    chk("rst_pix_xy", {pix_x, pix_y}, 32'h0);
    chk("rst_ints", {frame_int, line_int}, 2'b00);
    chk("rst_offsets", {offset_x, offset_y}, 32'h0);
    chk("rst2_syncs", {LCD_HSYNC2, LCD_VSYNC2}, 2'b00);

    rst_n = 1'b1; rst2_n = 1'b1;
    hs_low = 0; vs_low = 0; den_cnt = 0; pv_cnt = 0; fi_cnt = 0; li_cnt = 0;

    for (int cyc = 0; cyc < 4 * FT; cyc++) begin
      f = cyc / FT;
      border_en   = (f == 2);
      fixed_mode  = (f == 2);
      lia         = (f == 3) ? 4 : 2;
      line_int_at = 16'(lia);
      offset_x_in = (cyc >= 180) ? 16'd9 : 16'd5;

      a = act_at(cyc);
      chk("pix_valid", pix_valid, a);
      chk("pix_x", pix_x, a ? 32'(hx(cyc)) : 32'd0);
      chk("pix_y", pix_y, a ? 32'(vy(cyc)) : 32'd0);
      chk("frame_int", frame_int, (cyc > 0) && (cyc % FT == 0));
      chk("line_int", line_int, a && (hx(cyc) == 0) && (vy(cyc) == lia));
      chk("offset_x", offset_x, (cyc < FT) ? 16'd0 : (cyc < 2 * FT) ? 16'd5 : 16'd9);
      chk("offset_y", offset_y, (cyc < FT) ? 16'd0 : 16'hFFFD);

      s    = cyc - 3;
      as_  = act_at(s);
      hs_a = (s >= 0) && ((s % HT) < 2);
      vs_a = (s >= 0) && (((s / HT) % VT) < 1);
      chk("lcd_hsync", LCD_HSYNC, !hs_a);
      chk("lcd_vsync", LCD_VSYNC, !vs_a);
      chk("lcd_den", LCD_DEN, as_);
      rexp = 16'h0;
      if (as_) begin
        x = hx(s); y = vy(s);
        bord = (x == 0) || (x == 7) || (y == 0) || (y == 3);
        if ((s / FT) == 2) rexp = bord ? 16'hFFFF : 16'h1234;
        else               rexp = 16'(((y & 31) << 11) | ((x & 63) << 5));
      end
      chk("lcd_rgb", {LCD_R, LCD_G, LCD_B}, rexp);

      if (cyc >= 3 && cyc < 243) begin
        if (!LCD_HSYNC) hs_low++;
        if (!LCD_VSYNC) vs_low++;
        if (LCD_DEN) den_cnt++;
      end
      if (cyc < 2 * FT && pix_valid) pv_cnt++;
      if (cyc <= 2 * FT && frame_int) fi_cnt++;
      if (line_int) li_cnt++;
      @(negedge clk_pix);
    end

    chk("hsync_low_2frames", hs_low, 32);
    chk("vsync_low_2frames", vs_low, 30);
    chk("den_2frames", den_cnt, 64);
    chk("pix_valid_2frames", pv_cnt, 64);
    chk("frame_int_2frames", fi_cnt, 2);
    chk("line_int_4frames", li_cnt, 3);

    // dut2 has been free-running since release; go to x=3,y=0 of its active area.
    repeat (53) @(negedge clk_pix);
    chk("t6_pre_valid", pix_valid2, 1'b1);
    chk("t6_pre_den", LCD_DEN2, 1'b1);
    rst2_n = 1'b0;
    #1;
    chk("t6_rst_hsync", LCD_HSYNC2, 1'b0);
    chk("t6_rst_vsync", LCD_VSYNC2, 1'b0);
    chk("t6_rst_den", LCD_DEN2, 1'b0);
    chk("t6_rst_rgb", {LCD_R2, LCD_G2, LCD_B2}, 16'h0);
    chk("t6_rst_pix", {15'd0, pix_valid2, pix_x2, pix_y2}, 48'h0);
    chk("t6_rst_ints", {frame_int2, line_int2}, 2'b00);
    chk("t6_rst_offsets", {offset_x2, offset_y2}, 32'h0);
    @(negedge clk_pix);
    @(negedge clk_pix);
    rst2_n = 1'b1;

    first_den = -1;
    for (int k = 0; k < 135; k++) begin
      s = k - 1;
      as_ = act_at(s);
      chk("t6_pix_valid", pix_valid2, act_at(k));
      chk("t6_hsync", LCD_HSYNC2, (s >= 0) && ((s % HT) < 2));
      chk("t6_vsync", LCD_VSYNC2, (s >= 0) && (((s / HT) % VT) < 1));
      chk("t6_den", LCD_DEN2, as_);
      chk("t6_rgb", {LCD_R2, LCD_G2, LCD_B2}, as_ ? 16'hA5A5 : 16'h0);
      if (LCD_DEN2 && first_den < 0) first_den = k;
      @(negedge clk_pix);
    end
    chk("t6_first_den", first_den, 51);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
